control_fsm_param: RTL and testbench

- Registered, handshaked successor to the combinational instruction decoder in the MIPS datapath.
- Sits between instruction fetch/RAM and the datapath muxes, ALU, register file, RAM and multiplier.
- Decodes LW/SW/OpMat (ADD/SUB/MUL/AND/OR) into the control word.
- Sequences multi-cycle MUL through a start/done handshake with timeout, then issues a delayed register-file write-back.
- Register address width is parametrised; default packing is bit-identical to the existing 20-bit control word.

---
 rtl/control_fsm_param.sv | 206 ++++++++++++++++++++
 tb/tb_control_fsm_param.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_param.sv
// rtl/control_fsm_param.sv - registered, handshaked MIPS control decoder with multi-cycle MUL sequencing
`timescale 1ns/1ps

module control_fsm_param #(
    parameter int RW          = 4,
    parameter int MUL_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              mul_done,
    output logic [11+3*RW:0]  ctrl_out,
    output logic              ctrl_valid,
    output logic              busy,
    output logic              illegal_instr,
    output logic              mul_timeout
);

    localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

    // Low control bits, packed {we_regfile, sel_mux03, we_ram, sel_mux02, sel_alu[1:0], sel_mux01}
    localparam logic [6:0] SAFE_LOW   = 7'h18;
    localparam logic [6:0] LW_LOW     = 7'h79;
    localparam logic [6:0] SW_LOW     = 7'h29;
    localparam logic [6:0] ADD_LOW    = 7'h58;
    localparam logic [6:0] SUB_LOW    = 7'h5A;
    localparam logic [6:0] AND_LOW    = 7'h5C;
    localparam logic [6:0] OR_LOW     = 7'h5E;
    localparam logic [6:0] MUL_LOW    = 7'h10;
    localparam logic [6:0] WE_REG_BIT = 7'h40;

    localparam logic [5:0] OP_MAT = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_SW  = 6'd4;
    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_MUL = 6'd50;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        MUL_WAIT,
        MUL_WB
    } stateT;

    stateT            stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD, cntInc;
    logic             issueMulQ, issueMulD;
    logic [6:0]       lowQ, lowD;
    logic [RW-1:0]    rsQ, rsD, rtQ, rtD, rdQ, rdD;
    logic             startQ, startD;
    logic             validQ, validD;
    logic             illegalQ, illegalD;
    logic             timeoutQ, timeoutD;

    logic [6:0]       decLow;
    logic [RW-1:0]    decRs, decRt, decRd;
    logic             decMul, decIllegal;
    logic             accept, loadInstr;
    logic             unusedBits;

    // Only some instruction bits are decoded; fold the rest into a sink
    assign unusedBits = ^instr_in;

    assign instr_ready = (stateQ == IDLE) || (stateQ == MUL_WB) ||
                         ((stateQ == ISSUE) && !issueMulQ);
    assign accept      = instr_valid && instr_ready;
    assign cntInc      = cntQ + CNT_W'(1);

    // Decode the incoming instruction into its control bits and register addresses
    always_comb begin
        decLow     = SAFE_LOW;
        decMul     = 1'b0;
        decIllegal = 1'b0;
        decRs      = instr_in[20+RW:21];
        decRt      = instr_in[15+RW:16];
        decRd      = instr_in[10+RW:11];
        case (instr_in[31:26])
            OP_LW: begin
                decLow = LW_LOW;
                decRd  = instr_in[15+RW:16];
            end
            OP_SW: begin
                decLow = SW_LOW;
                decRd  = instr_in[15+RW:16];
            end
            OP_MAT: begin
                case (instr_in[5:0])
                    FN_ADD:  decLow = ADD_LOW;
                    FN_SUB:  decLow = SUB_LOW;
                    FN_AND:  decLow = AND_LOW;
                    FN_OR:   decLow = OR_LOW;
                    FN_MUL: begin
                        decLow = MUL_LOW;
                        decMul = 1'b1;
                    end
                    default: decIllegal = 1'b1;
                endcase
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // Next-state and next-output logic; addresses hold unless a new instruction loads
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        issueMulD = 1'b0;
        lowD      = SAFE_LOW;
        rsD       = rsQ;
        rtD       = rtQ;
        rdD       = rdQ;
        startD    = 1'b0;
        validD    = 1'b0;
        illegalD  = 1'b0;
        timeoutD  = 1'b0;
        loadInstr = 1'b0;
        case (stateQ)
            IDLE: begin
                if (accept) loadInstr = 1'b1;
            end
            ISSUE: begin
                if (issueMulQ) begin
                    stateD = MUL_WAIT;
                    cntD   = '0;
                    lowD   = lowQ;
                end else if (accept) begin
                    loadInstr = 1'b1;
                end else begin
                    stateD = IDLE;
                end
            end
            MUL_WAIT: begin
                lowD = lowQ;
                if (mul_done) begin
                    stateD = MUL_WB;
                    lowD   = lowQ | WE_REG_BIT;
                    validD = 1'b1;
                end else if (cntInc == CNT_W'(MUL_TIMEOUT)) begin
                    stateD   = IDLE;
                    lowD     = SAFE_LOW;
                    timeoutD = 1'b1;
                end else begin
                    cntD = cntInc;
                end
            end
            MUL_WB: begin
                if (accept) loadInstr = 1'b1;
                else        stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
        if (loadInstr) begin
            stateD    = ISSUE;
            lowD      = decLow;
            rsD       = decRs;
            rtD       = decRt;
            rdD       = decRd;
            startD    = decMul;
            issueMulD = decMul;
            validD    = 1'b1;
            illegalD  = decIllegal;
        end
    end

    // State and registered outputs; reset clears addresses and drops any multiply in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            issueMulQ <= 1'b0;
            lowQ      <= SAFE_LOW;
            rsQ       <= '0;
            rtQ       <= '0;
            rdQ       <= '0;
            startQ    <= 1'b0;
            validQ    <= 1'b0;
            illegalQ  <= 1'b0;
            timeoutQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            issueMulQ <= issueMulD;
            lowQ      <= lowD;
            rsQ       <= rsD;
            rtQ       <= rtD;
            rdQ       <= rdD;
            startQ    <= startD;
            validQ    <= validD;
            illegalQ  <= illegalD;
            timeoutQ  <= timeoutD;
        end
    end

    // Top four bits are reserved and driven 0 so the low bits match the legacy control word
    assign ctrl_out      = {4'b0000, startQ, rdQ, rtQ, rsQ, lowQ};
    assign ctrl_valid    = validQ;
    assign busy          = (stateQ == MUL_WAIT) || (stateQ == MUL_WB);
    assign illegal_instr = illegalQ;
    assign mul_timeout   = timeoutQ;

endmodule

// File: tb/tb_control_fsm_param.sv
// tb/tb_control_fsm_param.sv - randomized self-checking bench for control_fsm_param
`timescale 1ns/1ps

module tb_control_fsm_param;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrIn;
    logic        instrValid;
    logic        mulDone;

    logic        ready0, valid0, busy0, ill0, to0;
    logic [23:0] ctrl0;
    logic        ready1, valid1, busy1, ill1, to1;
    logic [26:0] ctrl1;

    int checks = 0;
    int errors = 0;

    control_fsm_param #(.RW(4), .MUL_TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst), .instr_in(instrIn), .instr_valid(instrValid),
        .instr_ready(ready0), .mul_done(mulDone), .ctrl_out(ctrl0),
        .ctrl_valid(valid0), .busy(busy0), .illegal_instr(ill0), .mul_timeout(to0)
    );

    control_fsm_param #(.RW(5), .MUL_TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .instr_in(instrIn), .instr_valid(instrValid),
        .instr_ready(ready1), .mul_done(mulDone), .ctrl_out(ctrl1),
        .ctrl_valid(valid1), .busy(busy1), .illegal_instr(ill1), .mul_timeout(to1)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 issuing, 2 waiting on multiplier, 3 write-back
    int          mPhase = 0;
    bit          mIssMul = 0;
    int          mWait = 0;
    logic [31:0] mInstr = 0;
    bit          mRdIsRt = 0;
    bit          mValid = 0, mIll = 0, mTo = 0;
    int          fMux01, fAlu, fMux02, fWeRam, fMux03, fWeReg, fStart;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit mReady();
        return (mPhase == 0) || (mPhase == 3) || (mPhase == 1 && !mIssMul);
    endfunction

    task automatic setSafe();
        fMux01 = 0; fAlu = 0; fMux02 = 1; fWeRam = 1; fMux03 = 0; fWeReg = 0; fStart = 0;
    endtask

    task automatic goIdle();
        mPhase = 0; mIssMul = 0; mValid = 0;
        setSafe();
    endtask

    task automatic load(input logic [31:0] ins);
        int op, fn;
        op = int'(ins[31:26]);
        fn = int'(ins[5:0]);
        mInstr = ins; mRdIsRt = 0; mIssMul = 0; mIll = 0; mValid = 1; mPhase = 1;
        setSafe();
        if (op == 3 || op == 4) begin
            fMux01 = 1; fMux03 = 1; mRdIsRt = 1;
            fWeRam = (op == 3) ? 1 : 0;
            fWeReg = (op == 3) ? 1 : 0;
        end else if (op == 2 && (fn == 32 || fn == 34 || fn == 36 || fn == 37)) begin
            fWeReg = 1;
            fAlu = (fn == 32) ? 0 : (fn == 34) ? 1 : (fn == 36) ? 2 : 3;
        end else if (op == 2 && fn == 50) begin
            fMux02 = 0; fStart = 1; mIssMul = 1;
        end else begin
            mIll = 1;
        end
    endtask

    function automatic longint expWord(input int rw);
        longint m, rs, rt, rd;
        m  = (longint'(1) << rw) - 1;
        rs = (longint'(mInstr) >> 21) & m;
        rt = (longint'(mInstr) >> 16) & m;
        rd = mRdIsRt ? rt : ((longint'(mInstr) >> 11) & m);
        return fMux01 + 2 * fAlu + 8 * fMux02 + 16 * fWeRam + 32 * fMux03 + 64 * fWeReg
             + (rs << 7) + (rt << (7 + rw)) + (rd << (7 + 2 * rw))
             + (longint'(fStart) << (7 + 3 * rw));
    endfunction

    task automatic modelStep();
        bit acc;
        if (!rst) begin
            goIdle();
            mWait = 0; mInstr = 0; mRdIsRt = 0; mIll = 0; mTo = 0;
            return;
        end
        acc = instrValid && mReady();
        mIll = 0;
        mTo = 0;
        if (mPhase == 1 && mIssMul) begin
            mPhase = 2; mWait = 0; fStart = 0; mValid = 0; mIssMul = 0;
        end else if (mPhase == 2) begin
            mWait++;
            if (mulDone) begin
                mPhase = 3; fWeReg = 1; mValid = 1;
            end else if (mWait == TO) begin
                goIdle();
                mTo = 1;
            end
        end else if (acc) begin
            load(instrIn);
        end else begin
            goIdle();
        end
    endtask

    task automatic compareAll();
        checkVal("ctrl_out_rw4", {40'd0, ctrl0}, expWord(4));
        checkVal("ctrl_out_rw5", {37'd0, ctrl1}, expWord(5));
        checkVal("ctrl_valid", valid0, mValid);
        checkVal("instr_ready", ready0, mReady());
        checkVal("busy", busy0, (mPhase == 2 || mPhase == 3));
        checkVal("illegal_instr", ill0, mIll);
        checkVal("mul_timeout", to0, mTo);
        checkVal("rw5_status", {ready1, valid1, busy1, ill1, to1},
                 {mReady(), mValid, (mPhase == 2 || mPhase == 3), mIll, mTo});
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareAll();
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        int k, f;
        w = $urandom();
        k = $urandom_range(0, 8);
        if (k == 0) w[31:26] = 6'd3;
        else if (k == 1) w[31:26] = 6'd4;
        else if (k <= 6) begin
            w[31:26] = 6'd2;
            f = $urandom_range(0, 4);
            w[5:0] = (f == 0) ? 6'd32 : (f == 1) ? 6'd34 : (f == 2) ? 6'd36 : (f == 3) ? 6'd37 : 6'd50;
        end else if (k == 7) w[31:26] = 6'(7 + $urandom_range(0, 56));
        else begin
            w[31:26] = 6'd2;
            w[5:0] = 6'h11;
        end
        return w;
    endfunction

    initial begin
        int pulses;
        rst = 1'b0; instrValid = 1'b0; instrIn = '0; mulDone = 1'b0;
        setSafe();
        @(negedge clk);

        step(); step();
        checkVal("reset_word", {40'd0, ctrl0}, 64'h18);
        checkVal("reset_ready", ready0, 1'b1);

        rst = 1'b1; instrValid = 1'b1; instrIn = 32'h0CA70000;
        step();
        checkVal("lw_word", {40'd0, ctrl0}, 64'h3BAF9);
        instrIn = 32'h08221820;
        step();
        checkVal("add_word", {40'd0, ctrl0}, 64'h190D8);
        instrIn = 32'h08221822;
        step();
        checkVal("sub_word", {40'd0, ctrl0}, 64'h190DA);
        checkVal("b2b_ready", ready0, 1'b1);

        instrIn = 32'h08221832;
        step();
        checkVal("mul_issue_word", {40'd0, ctrl0}, 64'h99090);
        instrIn = 32'h08221824;
        step();
        checkVal("mul_wait_ready", ready0, 1'b0);
        checkVal("mul_wait_busy", busy0, 1'b1);
        step();
        mulDone = 1'b1;
        step();
        checkVal("mul_wb_word", {40'd0, ctrl0}, 64'h190D0);
        mulDone = 1'b0;
        step();
        checkVal("held_after_wb", {40'd0, ctrl0}, 64'h190DC);

        instrIn = 32'h08221832;
        step();
        instrValid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            pulses += int'(to0);
        end
        checkVal("timeout_pulses", pulses, 1);

        instrValid = 1'b1; instrIn = 32'h1C221820;
        step();
        checkVal("illegal_op", ill0, 1'b1);
        instrIn = 32'h08221811;
        step();
        checkVal("illegal_funct", ill0, 1'b1);

        instrIn = 32'h08221832;
        step();
        instrValid = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1; mulDone = 1'b1;
        step();
        mulDone = 1'b0;
        checkVal("late_done_ignored", valid0, 1'b0);

        instrValid = 1'b1; instrIn = 32'h0BFEE820;
        step();
        checkVal("rw5_word", {37'd0, ctrl1}, 64'h3BEFD8);
        instrValid = 1'b0;
        step();

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) != 0);
            instrValid = ($urandom_range(0, 9) < 7);
            instrIn    = randInstr();
            mulDone    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
